clock_module: RTL and testbench

Real-time time-of-day counter. Divides the system clock down to a 1 Hz tick and keeps hours, minutes and seconds in BCD, 24-hour format. It supports manual setting of hours and minutes and has an optional alarm comparator. It sits between the board clock and the display/driver logic, which consumes the BCD outputs.

---
 rtl/clock_module.sv | 138 +++++++++++++
 tb/tb_clock_module.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_module.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : clock_module                                             |
// | Description : 24-hour BCD time-of-day counter. A prescaler divides     |
// |               clk by CLK_HZ to make a 1 Hz tick. Hours and minutes can |
// |               be set with single-cycle pulses.                         |
// |               Optional alarm comparator: define CLOCK_MODULE_ALARM_EN. |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module clock_module #(
  parameter int CLK_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hr,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_en,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       tick_1hz,
  output logic       alarm
);

  localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic [3:0]    hh_t, hh_u, mm_t, mm_u, ss_t, ss_u;
  logic [3:0]    hh_t_n, hh_u_n, mm_t_n, mm_u_n, ss_t_n, ss_u_n;
  logic          sec_tick, sec_carry, min_carry, min_step, hr_step;

  // Tick/carry decode and next-state of every BCD digit.
  always_comb begin
    sec_tick  = run && (presc == PRESC_MAX);
    sec_carry = sec_tick && (ss_t == 4'd5) && (ss_u == 4'd9);
    // A manual minute step replaces the seconds carry, and never ripples into hours.
    min_step  = inc_min || sec_carry;
    min_carry = sec_carry && !inc_min && (mm_t == 4'd5) && (mm_u == 4'd9);
    hr_step   = inc_hr || min_carry;

    ss_t_n = ss_t;
    ss_u_n = ss_u;
    mm_t_n = mm_t;
    mm_u_n = mm_u;
    hh_t_n = hh_t;
    hh_u_n = hh_u;

    if (sec_tick) begin
      if (ss_u == 4'd9) begin
        ss_u_n = 4'd0;
        ss_t_n = (ss_t == 4'd5) ? 4'd0 : ss_t + 4'd1;
      end else begin
        ss_u_n = ss_u + 4'd1;
      end
    end

    if (min_step) begin
      if (mm_u == 4'd9) begin
        mm_u_n = 4'd0;
        mm_t_n = (mm_t == 4'd5) ? 4'd0 : mm_t + 4'd1;
      end else begin
        mm_u_n = mm_u + 4'd1;
      end
    end

    if (hr_step) begin
      if ((hh_t == 4'd2) && (hh_u == 4'd3)) begin
        hh_t_n = 4'd0;
        hh_u_n = 4'd0;
      end else if (hh_u == 4'd9) begin
        hh_u_n = 4'd0;
        hh_t_n = hh_t + 4'd1;
      end else begin
        hh_u_n = hh_u + 4'd1;
      end
    end
  end

  // Prescaler: free-runs 0..CLK_HZ-1 while run is high, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (run) begin
      presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
    end
  end

  // Time digits and the one-cycle tick that accompanies each new second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_t     <= 4'd0;
      ss_u     <= 4'd0;
      mm_t     <= 4'd0;
      mm_u     <= 4'd0;
      hh_t     <= 4'd0;
      hh_u     <= 4'd0;
      tick_1hz <= 1'b0;
    end else begin
      ss_t     <= ss_t_n;
      ss_u     <= ss_u_n;
      mm_t     <= mm_t_n;
      mm_u     <= mm_u_n;
      hh_t     <= hh_t_n;
      hh_u     <= hh_u_n;
      tick_1hz <= sec_tick;
    end
  end

  assign hh_bcd = {hh_t, hh_u};
  assign mm_bcd = {mm_t, mm_u};
  assign ss_bcd = {ss_t, ss_u};

`ifdef CLOCK_MODULE_ALARM_EN
  logic alarm_q;

  // Alarm sets at second 00 of the matching minute and holds while hh:mm still match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_en && (hh_bcd == alarm_hh) && (mm_bcd == alarm_mm) &&
                 ((ss_bcd == 8'h00) || alarm_q);
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{alarm_hh, alarm_mm, alarm_en};
  assign alarm = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_module.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_clock_module                                          |
// | Description : Scoreboard bench for clock_module (CLK_HZ = 4). A time   |
// |               model kept as plain integers predicts each cycle; a      |
// |               negedge monitor compares the DUT against the queue.      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_clock_module;

  localparam int CLK_HZ = 4;
`ifdef CLOCK_MODULE_ALARM_EN
  localparam bit ALARM_BUILD = 1'b1;
`else
  localparam bit ALARM_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hr = 1'b0;
  logic [7:0] alarm_hh = 8'h00;
  logic [7:0] alarm_mm = 8'h01;
  logic       alarm_en = 1'b1;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic       tick_1hz, alarm;

  clock_module #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .inc_min  (inc_min),
    .inc_hr   (inc_hr),
    .alarm_hh (alarm_hh),
    .alarm_mm (alarm_mm),
    .alarm_en (alarm_en),
    .hh_bcd   (hh_bcd),
    .mm_bcd   (mm_bcd),
    .ss_bcd   (ss_bcd),
    .tick_1hz (tick_1hz),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       tick;
    logic       alarm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: time as integers, prescaler phase as an integer.
  int m_h = 0, m_m = 0, m_s = 0, m_pc = 0;
  bit m_al = 1'b0;

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_pc = 0; m_al = 1'b0;
  endtask

  // One clock cycle of stimulus; the model predicts and queues the outcome.
  task automatic cyc(input bit r, input bit im, input bit ih);
    bit tk, cm, ch, nal;
    run = r; inc_min = im; inc_hr = ih;
    @(posedge clk);
    nal = ALARM_BUILD && alarm_en && (bcd(m_h) == alarm_hh) &&
          (bcd(m_m) == alarm_mm) && ((m_s == 0) || m_al);
    tk = r && (m_pc == CLK_HZ - 1);
    if (r) m_pc = (m_pc + 1) % CLK_HZ;
    cm = 1'b0;
    ch = 1'b0;
    if (tk) begin
      m_s = (m_s + 1) % 60;
      cm  = (m_s == 0);
    end
    if (im) m_m = (m_m + 1) % 60;
    else if (cm) begin
      m_m = (m_m + 1) % 60;
      ch  = (m_m == 0);
    end
    if (ih || ch) m_h = (m_h + 1) % 24;
    m_al = nal;
    q.push_back('{bcd(m_h), bcd(m_m), bcd(m_s), tk, nal});
    #1;
  endtask

  task automatic repeat_cyc(input int n, input bit r, input bit im, input bit ih);
    for (int i = 0; i < n; i++) cyc(r, im, ih);
  endtask

  // Called just after a cycle: assert reset between edges, release after the next edge.
  task automatic reset_dut();
    run = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_time(input string name, input logic [23:0] hms);
    check(name, {hh_bcd, mm_bcd, ss_bcd}, hms);
  endtask

  // Monitor: every out-of-reset cycle with a prediction pending is compared.
  always @(negedge clk) begin
    if (rst_n && (q.size() > 0)) begin
      e = q.pop_front();
      check("state", {hh_bcd, mm_bcd, ss_bcd, tick_1hz, alarm},
            {e.hh, e.mm, e.ss, e.tick, e.alarm});
    end
  end

  initial begin
    int rem, n;
    bit seen;

    // Reset state with run already high.
    run = 1'b1;
    #2 rst_n = 1'b0;
    #21;
    check("reset_outputs", {hh_bcd, mm_bcd, ss_bcd, tick_1hz, alarm}, 26'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // First second lands on the 4th edge; one minute after 240 edges.
    repeat_cyc(3, 1'b1, 1'b0, 1'b0);
    check("no_early_tick", {31'h0, tick_1hz}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0);
    check("first_tick", {23'h0, tick_1hz, ss_bcd}, {23'h0, 1'b1, 8'h01});
    repeat_cyc(236, 1'b1, 1'b0, 1'b0);
    check_time("one_minute", 24'h000100);
    repeat_cyc(240, 1'b1, 1'b0, 1'b0);
    check_time("two_minutes", 24'h000200);

    // Freeze mid-second, then the tick arrives after only the remaining count.
    repeat_cyc(2, 1'b1, 1'b0, 1'b0);
    rem = CLK_HZ - m_pc;
    repeat_cyc(10, 1'b0, 1'b0, 1'b0);
    check_time("frozen_time", 24'h000200);
    n = 0;
    seen = 1'b0;
    while (!seen && (n < 2 * CLK_HZ)) begin
      cyc(1'b1, 1'b0, 1'b0);
      n++;
      seen = tick_1hz;
    end
    check("resume_latency", n, rem);

    // Preload 23:59:00, run to 23:59:58, then through midnight.
    reset_dut();
    repeat_cyc(23, 1'b0, 1'b0, 1'b1);
    repeat_cyc(59, 1'b0, 1'b1, 1'b0);
    repeat_cyc(58 * CLK_HZ, 1'b1, 1'b0, 1'b0);
    check_time("preload", 24'h235958);
    repeat_cyc(CLK_HZ, 1'b1, 1'b0, 1'b0);
    check_time("last_second", 24'h235959);
    repeat_cyc(CLK_HZ, 1'b1, 1'b0, 1'b0);
    check_time("midnight", 24'h000000);

    // inc_min on the 00:59:59 rollover edge drops the carry into hours.
    reset_dut();
    repeat_cyc(59, 1'b0, 1'b1, 1'b0);
    repeat_cyc(59 * CLK_HZ + CLK_HZ - 1, 1'b1, 1'b0, 1'b0);
    check_time("pre_rollover", 24'h005959);
    cyc(1'b1, 1'b1, 1'b0);
    check_time("set_vs_carry", 24'h000000);
    repeat_cyc(9, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("mm_09_to_10", {24'h0, mm_bcd}, 32'h10);

    // Asynchronous reset between edges at 12:34:56.
    reset_dut();
    repeat_cyc(12, 1'b0, 1'b0, 1'b1);
    repeat_cyc(34, 1'b0, 1'b1, 1'b0);
    repeat_cyc(56 * CLK_HZ, 1'b1, 1'b0, 1'b0);
    check_time("pre_async", 24'h123456);
    #2 rst_n = 1'b0;
    q.delete();
    model_reset();
    #1;
    check("async_clear", {hh_bcd, mm_bcd, ss_bcd, tick_1hz, alarm}, 26'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic, including stalls, set pulses and alarm changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        alarm_hh = bcd(int'($urandom_range(0, 23)));
        alarm_mm = bcd(int'($urandom_range(0, 59)));
        alarm_en = 1'($urandom_range(0, 3) != 0);
      end
      cyc(1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 49) == 0));
    end

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
